// File: rtl/mem_stage_if.sv
// Bundle of the pipeline-side request/response signals and the 16-bit SRAM bus
// seen by the memory-access stage.
interface mem_stage_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_result;
  logic [31:0] ST_val;
  logic [31:0] mem_read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  // The stage itself
  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
    output mem_read_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  // Pipeline plus SRAM surrounding the stage
  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
    input  mem_read_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: splits each 32-bit load/store into two half-word SRAM
// accesses (low then high), freezing the pipeline via ready until done.
module mem_stage #(
  parameter int unsigned SRAM_WAIT = 1,
  parameter logic [31:0] ADDR_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_phase;
  logic        r_wr;
  logic [16:0] r_word;
  logic [15:0] r_hi_data;
  logic [15:0] r_lo;
  logic [31:0] r_rdata;
  logic [17:0] r_addr;
  logic [15:0] r_dq_out;
  logic        r_oe;
  logic        r_we_n;

  logic        w_req;
  logic        w_last;
  logic [16:0] w_word;

  assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_last = (r_phase == 3'(SRAM_WAIT));
  // Word index of the base-relative byte address; wraps modulo 2^17 by truncation.
  assign w_word = 17'((bus.ALU_result - ADDR_BASE) >> 2);

  assign bus.ready         = (r_state == DONE) || ((r_state == IDLE) && !w_req);
  assign bus.mem_read_data = r_rdata;
  assign bus.SRAM_ADDR     = r_addr;
  assign bus.SRAM_DQ_out   = r_dq_out;
  assign bus.SRAM_DQ_oe    = r_oe;
  assign bus.SRAM_WE_N     = r_we_n;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so bus outputs change in lock-step with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_wr      <= 1'b0;
      r_word    <= '0;
      r_hi_data <= '0;
      r_lo      <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_dq_out  <= '0;
      r_oe      <= 1'b0;
      r_we_n    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // A store wins when both enables are raised together.
            r_wr      <= bus.MEM_W_EN;
            r_word    <= w_word;
            r_hi_data <= bus.ST_val[31:16];
            r_phase   <= '0;
            r_addr    <= {w_word, 1'b0};
            if (bus.MEM_W_EN) r_dq_out <= bus.ST_val[15:0];
            r_we_n    <= !bus.MEM_W_EN;
            r_oe      <= bus.MEM_W_EN;
            r_state   <= LOW;
          end
        end
        LOW: begin
          if (w_last) begin
            if (!r_wr) r_lo <= bus.SRAM_DQ_in;
            if (r_wr)  r_dq_out <= r_hi_data;
            r_phase <= '0;
            r_addr  <= {r_word, 1'b1};
            r_state <= HIGH;
          end else begin
            r_phase <= r_phase + 3'd1;
          end
        end
        HIGH: begin
          if (w_last) begin
            if (!r_wr) r_rdata <= {bus.SRAM_DQ_in, r_lo};
            r_phase <= '0;
            r_we_n  <= 1'b1;
            r_oe    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_phase <= r_phase + 3'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 32-bit pipeline, directly downstream of the execute stage.
- Consumes the execute stage's ALU result as a byte address and the forwarded second register value as store data.
- Performs loads and stores on an external 16-bit-wide SRAM using two half-word accesses per word.
- Drops a ready flag that freezes the pipeline until the access completes.

Parameters:
SRAM_WAIT, 1, extra cycles each half-word phase is held (phase length = SRAM_WAIT+1 cycles); legal range 0..7
ADDR_BASE, 1024, byte address mapped to SRAM word 0

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
MEM_R_EN  input  1  load request; held stable by the pipeline while ready=0
MEM_W_EN  input  1  store request; held stable while ready=0
ALU_result  input  32  byte address from execute stage
ST_val  input  32  store data
mem_read_data  output  32  last completed load word
ready  output  1  1 = stage may advance; 0 = freeze pipeline
SRAM_ADDR  output  18  half-word address to SRAM
SRAM_DQ_in  input  16  SRAM read data
SRAM_DQ_out  output  16  SRAM write data
SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto the bus
SRAM_WE_N  output  1  SRAM write enable, active low

Behaviour:
- Clock and reset: one clock domain `clk`; `rst` is asynchronous and active-high.
- Reset values: state=IDLE; mem_read_data=0; SRAM_ADDR=0; SRAM_DQ_out=0; SRAM_DQ_oe=0; SRAM_WE_N=1.
- Reset mid-operation aborts immediately and asynchronously: WE_N=1, oe=0, no partial result written to mem_read_data.
- States: IDLE, LOW, HIGH, DONE.
- IDLE, no request: ready=1, bus idle.
- IDLE, with MEM_R_EN|MEM_W_EN: ready=0 (combinational). On the next edge:
  - latch req_wr = MEM_W_EN (write has priority if both asserted), req_data = ST_val;
  - latch word = (ALU_result - ADDR_BASE)[18:2] (17 bits; low 2 bits ignored; out-of-range wraps modulo 2^17);
  - go to LOW.
- LOW: SRAM_ADDR = {word,0}. Held SRAM_WAIT+1 cycles by a phase counter, then go to HIGH.
  - Write: WE_N=0, oe=1, DQ_out=req_data[15:0].
  - Read: WE_N=1, oe=0; SRAM_DQ_in captured into lo register on the final LOW cycle.
- HIGH: same as LOW with SRAM_ADDR = {word,1}.
  - Write data is req_data[31:16].
  - Read: on the final cycle, mem_read_data <= {SRAM_DQ_in, lo} (registered).
- DONE: WE_N=1, oe=0, ready=1 for exactly one cycle; unconditionally go to IDLE.
- Latency: a request first seen in cycle 0 gives ready=0 for cycles 0..2*SRAM_WAIT+2 and ready=1 in cycle 2*SRAM_WAIT+3. Example: SRAM_WAIT=1 gives ready=1 in cycle 5.
- Request inputs are ignored outside IDLE; only latched values are used.
- Back-to-back: a request still present in the IDLE cycle after DONE is treated as new. The pipeline is expected to have advanced, so the request seen is the next instruction's.
- Stores never change mem_read_data. Loads update it only at completion; it holds its value otherwise.
- WE_N and oe are always both inactive in IDLE and DONE, giving one turnaround cycle between operations.

Test Plan:
- Reset pulse mid-idle -> all outputs at reset values; ready=1 with no request; WE_N=1.
- Store, SRAM_WAIT=1: ALU_result=1028, ST_val=0xDEADBEEF ->
  - cycles 1-2: ADDR=2, DQ_out=0xBEEF, WE_N=0, oe=1;
  - cycles 3-4: ADDR=3, DQ_out=0xDEAD;
  - cycle 5: ready=1;
  - ready=0 in cycles 0-4.
- Load of the same address from the SRAM behavioural model -> cycle 5: ready=1, mem_read_data=0xDEADBEEF; WE_N stays 1 and oe stays 0 throughout.
- Load at ALU_result=1024 followed immediately by a store at 1032 -> load completes with ready=1 in cycle 5; store starts with IDLE in cycle 6, ADDR=4 in cycles 7-8, ready=1 in cycle 11; mem_read_data unchanged by the store.
- MEM_R_EN=1 and MEM_W_EN=1 together, ST_val=0x12345678 at ALU_result=1024 -> write performed (WE_N=0 on ADDR 0 then 1); mem_read_data unchanged.
- rst asserted in cycle 3 of a store -> WE_N=1 and oe=0 without waiting for an edge; state IDLE; after release with no request, ready=1. SRAM_WAIT=0 variant of the store -> ready=1 in cycle 3.
